lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the core's memory stage and the byte-addressed data memory.
- Accepts one RISC-V load/store (func3-encoded) per handshake and turns it into word-addressed memory beats with byte enables.
- Splits word-crossing accesses into two beats and returns sign- or zero-extended load data.
- Memory side is a synchronous-read, 32-bit-wide, byte-enabled array of 2**ADDR_W bytes.

Parameters:
ADDR_W, 12, byte-address width (4 KiB default); memory word address is ADDR_W-2 bits

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  core request valid
req_ready_o  out  1  controller can accept request
req_we_i  in  1  1=store, 0=load
req_func3_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  32  store data, LSB-aligned
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  32  extended load data (0 for stores/errors)
resp_err_o  out  1  illegal func3 (qualified by resp_valid_o)
mem_en_o  out  1  memory beat valid
mem_wren_o  out  1  beat is write
mem_addr_o  out  ADDR_W-2  word address
mem_be_o  out  4  byte enables, bit i = byte lane i
mem_wdata_o  out  32  lane-aligned write data
mem_rdata_i  in  32  read word, valid cycle after read beat

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Endianness: little-endian, byte lane i = bits 8i+7:8i. Size n = 1/2/4 bytes; off = addr[1:0]; split when off+n > 4.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
  - IDLE: req_ready_o=1. Handshake on req_valid_i&req_ready_o (cycle N) captures we/func3/addr/wdata. Legal request -> BEAT0. Illegal -> DONE with error.
  - BEAT0 (N+1): mem_en_o=1, mem_addr_o=addr[ADDR_W-1:2]. Split -> BEAT1, else DONE.
  - BEAT1 (N+2): mem_en_o=1, mem_addr_o=word0+1, wrapping modulo 2**(ADDR_W-2). Read data of beat0 captured into lo register this cycle. -> DONE.
  - DONE: resp_valid_o=1 for exactly one cycle, then -> IDLE. req_ready_o=0 in every state except IDLE; no response backpressure.
- Latency: unsplit at N+2, split at N+3, illegal func3 at N+1.
- Illegal func3 = load 011/110/111 or store anything but 000/001/010. Gives resp_err_o=1, rdata 0, no memory beat.
- Store beats:
  - Beat0: be = (2**n-1)<<off truncated to 4 bits; wdata = req_wdata<<(8*off).
  - Beat1: be = (2**n-1)>>(4-off); wdata = req_wdata>>(8*(4-off)).
  - Lanes with be=0 carry don't-care data (drive 0).
- Load data:
  - Form 64-bit {hi,lo}: lo = beat0 word (captured, or mem_rdata_i in DONE if unsplit); hi = mem_rdata_i in DONE if split.
  - Shift right by 8*off, keep n bytes.
  - func3 000/001 sign-extend from bit 8n-1; 100/101 zero-extend; 010 unchanged.
  - resp_rdata_o is 0 for stores.
- mem_wren_o = captured we during BEAT0/BEAT1, 0 otherwise. mem_be_o = 1111 on read beats.
- Reset mid-operation: immediate return to IDLE, outputs 0, no response. A beat0 store already committed is not rolled back.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a split-requiring access is not split. It goes IDLE->DONE with resp_err_o=1, response at N+1, no memory beat. BEAT1 logic is removed.
- Undefined: split access as above; resp_err_o only for illegal func3.

Test Plan:
- sw 0xDEADBEEF @0x100 -> single beat word 0x040, be 1111, wdata 0xDEADBEEF, resp_valid at N+2, err 0.
- word 0x040=0x80112233; lb @0x103 -> 0xFFFFFF80; lbu @0x103 -> 0x00000080; lh @0x102 -> 0xFFFF8011.
- word 0x03F=0xAABBCCDD, 0x040=0x44332211; lw @0x0FE -> beats 0x03F then 0x040, resp at N+3, rdata 0x2211AABB.
- sh 0xBEEF @0xFFF -> beat0 word 0x3FF be 1000 wdata 0xEF000000; beat1 word 0x000 be 0001 wdata 0x000000BE (wrap).
- load func3 011 and store func3 100 -> resp_err 1 at N+1, rdata 0, mem_en never asserted; with LSU_MISALIGN_TRAP_EN, lw @0x0FE -> err 1 at N+1, no beat.
- rst_n_i low during BEAT1 of split sw -> all outputs 0 immediately, no resp_valid; next request after release completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
`timescale 1ns/1ps
// lsu_mem_ctrl: load/store initiator turning func3-encoded core requests into byte-enabled word beats.
// Ports: clk_i/rst_n_i (async active-low); req_* core request handshake (valid/ready, we, func3, addr, wdata);
// resp_* one-cycle completion pulse with extended load data and illegal-access error;
// mem_* synchronous-read 32-bit byte-enabled memory beats (en, wren, word addr, be, wdata, rdata).
// Build option LSU_MISALIGN_TRAP_EN: word-crossing accesses are rejected with an error instead of being split.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_func3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_en_o,
  output logic              mem_wren_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);
  localparam logic [1:0] IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, DONE = 2'd3;
  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    logic [2:0] sz;
    sz = f3[1] ? 3'd4 : (f3[0] ? 3'd2 : 3'd1);
    return ({1'b0, off} + sz) > 3'd4;
  endfunction
  logic [1:0]        state_q, state_d;
  logic              ready_q, we_q, err_q, hs, illegal_in, bad_in, split;
  logic              beat, hi_beat, done;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, lo_q, d;
  logic [3:0]        m;
  logic [7:0]        be_w;
  logic [63:0]       wd_w, rd64;
  assign hs = req_valid_i & ready_q;
  assign illegal_in = req_we_i ? (req_func3_i[2] | (&req_func3_i[1:0]))
                               : ((&req_func3_i[1:0]) | (&req_func3_i[2:1]));
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_in = illegal_in | crosses(req_func3_i, req_addr_i[1:0]);
  assign split  = 1'b0;
  assign lo_q   = '0;
`else
  assign bad_in = illegal_in;
  assign split  = crosses(f3_q, addr_q[1:0]);
  // Beat0 read data returns while beat1 is issued; hold it as the low word.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) lo_q <= '0;
    else if (state_q == BEAT1) lo_q <= mem_rdata_i;
`endif
  always_comb
    state_d = state_q == IDLE  ? (hs ? (bad_in ? DONE : BEAT0) : IDLE) :
              state_q == BEAT0 ? (split ? BEAT1 : DONE) :
              state_q == BEAT1 ? DONE : IDLE;
  // Ready is registered so it reads 0 while in reset and only rises once the FSM runs.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == IDLE;
      if (hs) begin
        we_q    <= req_we_i;
        err_q   <= bad_in;
        f3_q    <= req_func3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  assign req_ready_o = ready_q;
  assign beat    = (state_q == BEAT0) | (state_q == BEAT1);
  assign hi_beat = state_q == BEAT1;
  assign done    = state_q == DONE;
  // Byte mask of the access size; shifting it (and the masked data) by the offset
  // across 64 bits gives beat0 in the low half and beat1 in the high half.
  assign m    = f3_q[1] ? 4'hF : (f3_q[0] ? 4'h3 : 4'h1);
  assign be_w = {4'b0, m} << addr_q[1:0];
  assign wd_w = {32'b0, wdata_q & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}}} << {addr_q[1:0], 3'b000};
  assign mem_en_o    = beat;
  assign mem_wren_o  = beat & we_q;
  assign mem_addr_o  = beat ? addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, hi_beat} : '0;
  assign mem_be_o    = !beat ? 4'h0 : !we_q ? 4'hF : hi_beat ? be_w[7:4] : be_w[3:0];
  assign mem_wdata_o = !(beat & we_q) ? '0 : hi_beat ? wd_w[63:32] : wd_w[31:0];
  assign rd64 = split ? {mem_rdata_i, lo_q} : {32'b0, mem_rdata_i};
  assign d    = 32'(rd64 >> {addr_q[1:0], 3'b000});
  assign resp_valid_o = done;
  assign resp_err_o   = done & err_q;
  assign resp_rdata_o = !(done & !we_q & !err_q) ? '0 :
                        f3_q == 3'b000 ? {{24{d[7]}}, d[7:0]} :
                        f3_q == 3'b001 ? {{16{d[15]}}, d[15:0]} :
                        f3_q == 3'b100 ? {24'b0, d[7:0]} :
                        f3_q == 3'b101 ? {16'b0, d[15:0]} : d;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
`timescale 1ns/1ps
// tb_lsu_mem_ctrl: directed and random load/store checks against a byte-array reference model.
module tb_lsu_mem_ctrl;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk_i = 1'b0, rst_n_i, req_valid_i, req_we_i;
  logic        req_ready_o, resp_valid_o, resp_err_o, mem_en_o, mem_wren_o;
  logic [2:0]  req_func3_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i, resp_rdata_o, mem_wdata_o, mem_rdata_i = '0;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem [1024];
  logic [7:0]  model_mem [4096];
  logic        bd_en = 1'b0;
  logic [9:0]  bd_w = '0;
  logic [31:0] bd_v = '0;
  logic [31:0] last_rd;
  logic        last_err;
  int total = 0, bad = 0;

  lsu_mem_ctrl #(.ADDR_W(12)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_func3_i(req_func3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_en_o(mem_en_o), .mem_wren_o(mem_wren_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (bd_en) mem[bd_w] <= bd_v;
    else if (mem_en_o) begin
      for (int l = 0; l < 4; l++)
        if (mem_wren_o && mem_be_o[l]) mem[mem_addr_o][8*l +: 8] <= mem_wdata_o[8*l +: 8];
      mem_rdata_i <= mem[mem_addr_o];
    end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    bd_w = 10'(w);
    bd_v = v;
    bd_en = 1'b1;
    for (int i = 0; i < 4; i++) model_mem[4*w + i] = v[8*i +: 8];
    @(posedge clk_i); #1;
    bd_en = 1'b0;
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
    int n, off, k, nb, exp_nb, exp_lat, b;
    logic legal, split, err;
    logic [31:0] v, exp_rd;
    logic [9:0]  ew [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [9:0]  ow [4];
    logic [3:0]  obe [4];
    logic [31:0] owd [4];
    logic        owr [4];
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    off = int'(a[1:0]);
    split = off + n > 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || (TRAP && split);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[(int'(a) + i) % 4096];
    exp_rd = (err || we) ? 32'h0 :
             f3 == 3'd0 ? 32'(signed'(v[7:0])) :
             f3 == 3'd1 ? 32'(signed'(v[15:0])) :
             f3 == 3'd4 ? {24'h0, v[7:0]} :
             f3 == 3'd5 ? {16'h0, v[15:0]} : v;
    exp_nb  = err ? 0 : split ? 2 : 1;
    exp_lat = err ? 1 : split ? 3 : 2;
    for (int j = 0; j < 2; j++) begin
      ew[j]  = 10'(((int'(a) >> 2) + j) % 1024);
      ebe[j] = we ? 4'h0 : 4'hF;
      ewd[j] = '0;
      if (we)
        for (int i = 0; i < n; i++) begin
          b = (int'(a) + i) % 4096;
          if ((b >> 2) == int'(ew[j])) begin
            ebe[j][b % 4] = 1'b1;
            ewd[j][8*(b % 4) +: 8] = wd[8*i +: 8];
          end
        end
    end
    k = 0;
    while (req_ready_o !== 1'b1 && k < 10) begin @(posedge clk_i); #1; k++; end
    chk("ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_func3_i = f3; req_addr_i = a; req_wdata_i = wd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_wdata_i = $urandom;
    k = 1; nb = 0;
    while (resp_valid_o !== 1'b1 && k < 8) begin
      if (mem_en_o === 1'b1) begin
        if (nb < 4) begin
          ow[nb] = mem_addr_o; obe[nb] = mem_be_o; owd[nb] = mem_wdata_o; owr[nb] = mem_wren_o;
        end
        nb++;
      end
      chk("ready_busy", {31'b0, req_ready_o}, 32'd0);
      @(posedge clk_i); #1;
      k++;
    end
    chk("latency", k, exp_lat);
    chk("resp_valid", {31'b0, resp_valid_o}, 32'd1);
    chk("resp_rdata", resp_rdata_o, exp_rd);
    chk("resp_err", {31'b0, resp_err_o}, {31'b0, err});
    chk("beats", nb, exp_nb);
    chk("done_no_beat", {31'b0, mem_en_o}, 32'd0);
    for (int j = 0; j < exp_nb; j++)
      if (j < nb) begin
        chk("beat_addr", {22'b0, ow[j]}, {22'b0, ew[j]});
        chk("beat_be", {28'b0, obe[j]}, {28'b0, ebe[j]});
        chk("beat_wren", {31'b0, owr[j]}, {31'b0, we});
        if (we) chk("beat_wdata", owd[j], ewd[j]);
      end
    last_rd = resp_rdata_o;
    last_err = resp_err_o;
    @(posedge clk_i); #1;
    chk("resp_pulse", {31'b0, resp_valid_o}, 32'd0);
    chk("ready_after", {31'b0, req_ready_o}, 32'd1);
    if (we && !err)
      for (int i = 0; i < n; i++) model_mem[(int'(a) + i) % 4096] = wd[8*i +: 8];
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {13'b0, req_ready_o, resp_valid_o, resp_err_o, mem_en_o, mem_wren_o, mem_addr_o, mem_be_o}, 32'd0);
    chk(tag, resp_rdata_o, 32'd0);
    chk(tag, mem_wdata_o, 32'd0);
  endtask

  initial begin
    int k;
    rst_n_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_func3_i = '0; req_addr_i = '0; req_wdata_i = '0;
    #2 rst_n_i = 1'b0;
    #1 chk_all_zero("reset_outs");
    for (int w = 0; w < 1024; w++) set_word(w, $urandom);
    chk_all_zero("reset_hold");
    rst_n_i = 1'b1;

    run(1'b1, 3'b010, 12'h100, 32'hDEADBEEF);
    chk("sw_mem", mem[10'h040], 32'hDEADBEEF);
    set_word(10'h040, 32'h80112233);
    run(1'b0, 3'b000, 12'h103, 32'h0);
    chk("lb_const", last_rd, 32'hFFFFFF80);
    run(1'b0, 3'b100, 12'h103, 32'h0);
    chk("lbu_const", last_rd, 32'h00000080);
    run(1'b0, 3'b001, 12'h102, 32'h0);
    chk("lh_const", last_rd, 32'hFFFF8011);
    set_word(10'h03F, 32'hAABBCCDD);
    set_word(10'h040, 32'h44332211);
    run(1'b0, 3'b010, 12'h0FE, 32'h0);
    chk("lw_split", last_rd, TRAP ? 32'h0 : 32'h2211AABB);
    chk("lw_split_err", {31'b0, last_err}, {31'b0, TRAP});
    set_word(10'h3FF, 32'h0);
    set_word(10'h000, 32'h0);
    run(1'b1, 3'b001, 12'hFFF, 32'h1234BEEF);
    chk("sh_wrap_hi", mem[10'h3FF], TRAP ? 32'h0 : 32'hEF000000);
    chk("sh_wrap_lo", mem[10'h000], TRAP ? 32'h0 : 32'h000000BE);
    run(1'b0, 3'b011, 12'h010, 32'h0);
    chk("ld_illegal", {31'b0, last_err}, 32'd1);
    run(1'b1, 3'b100, 12'h014, 32'hFFFFFFFF);
    chk("st_illegal", {31'b0, last_err}, 32'd1);

    k = 0;
    while (req_ready_o !== 1'b1 && k < 10) begin @(posedge clk_i); #1; k++; end
    req_valid_i = 1'b1; req_we_i = 1'b1; req_func3_i = 3'b010; req_addr_i = 12'h1FE; req_wdata_i = 32'h11223344;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1 chk_all_zero("midop_reset");
    if (!TRAP) begin
      model_mem[12'h1FE] = 8'h44;
      model_mem[12'h1FF] = 8'h33;
    end
    @(posedge clk_i); #1;
    chk("midop_no_resp", {31'b0, resp_valid_o}, 32'd0);
    rst_n_i = 1'b1;
    run(1'b0, 3'b010, 12'h1FC, 32'h0);
    run(1'b1, 3'b000, 12'h1FD, 32'h000000A5);
    run(1'b0, 3'b010, 12'h1FC, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic [11:0] a;
      a = 12'($urandom);
      if (i % 5 == 0) a[11:2] = (i % 10 == 0) ? 10'h3FF : 10'h000;
      run(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
